// File: rtl/ex_stage_mc_if.sv
// Handshake and operand bundle between the ID/EX register, the execute stage and EX/MEM.
// master drives instructions and consumes results; slave is the execute stage.
interface ex_stage_mc_if #(
  parameter int unsigned WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [1:0]       alu_src;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] da;
  logic [WIDTH-1:0] db;
  logic [WIDTH-1:0] imm12_ext;
  logic [WIDTH-1:0] imm9_ext;
  logic [WIDTH-1:0] imm_branch;
  logic [WIDTH-1:0] mem_fwd;
  logic [WIDTH-1:0] wb_fwd;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] fwd_db_out;
  logic [WIDTH-1:0] branch_pc;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry;
  logic             busy;

  modport master (
    output in_valid, op, alu_src, fwd_a, fwd_b, pc, da, db, imm12_ext, imm9_ext,
           imm_branch, mem_fwd, wb_fwd, out_ready,
    input  in_ready, out_valid, alu_out, fwd_db_out, branch_pc, negative, zero,
           overflow, carry, busy
  );

  modport slave (
    input  in_valid, op, alu_src, fwd_a, fwd_b, pc, da, db, imm12_ext, imm9_ext,
           imm_branch, mem_fwd, wb_fwd, out_ready,
    output in_ready, out_valid, alu_out, fwd_db_out, branch_pc, negative, zero,
           overflow, carry, busy
  );
endinterface

// File: rtl/ex_stage_mc.sv
// Handshaked WIDTH-generic execute stage: forwarding, ALU-source select, branch target, ALU.
// Define EX_MUL_EN to compile in the iterative shift-add multiplier (op 001).
module ex_stage_mc #(
  parameter int unsigned WIDTH    = 64,
  parameter int unsigned BR_SHIFT = 2
) (
  input  logic         clk,
  input  logic         reset,
  ex_stage_mc_if.slave ex_if
);

  localparam int unsigned SUM_W = WIDTH + 1;

  localparam logic [2:0] OP_MUL = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;

  logic [WIDTH-1:0] a_c;
  logic [WIDTH-1:0] db_c;
  logic [WIDTH-1:0] b_c;
  logic [WIDTH-1:0] b_eff_c;
  logic [WIDTH-1:0] res_c;
  logic [WIDTH-1:0] bpc_c;
  logic [SUM_W-1:0] sum_c;
  logic             cy_c;
  logic             ov_c;

  logic             valid_q;
  logic             busy_q;
  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] db_q;
  logic [WIDTH-1:0] bpc_q;
  logic             n_q;
  logic             z_q;
  logic             v_q;
  logic             c_q;

  logic             out_free_c;
  logic             in_ready_c;
  logic             accept_c;
  logic             mul_start_c;
  logic             load_alu_c;

  // Operand forwarding and B-source selection
  always_comb begin
    a_c = ex_if.da;
    case (ex_if.fwd_a)
      2'b01:   a_c = ex_if.mem_fwd;
      2'b10:   a_c = ex_if.wb_fwd;
      default: a_c = ex_if.da;
    endcase
    db_c = ex_if.db;
    case (ex_if.fwd_b)
      2'b01:   db_c = ex_if.mem_fwd;
      2'b10:   db_c = ex_if.wb_fwd;
      default: db_c = ex_if.db;
    endcase
    b_c = db_c;
    case (ex_if.alu_src)
      2'b01:   b_c = ex_if.imm12_ext;
      2'b10:   b_c = ex_if.imm9_ext;
      2'b11:   b_c = '0;
      default: b_c = db_c;
    endcase
    bpc_c = ex_if.pc + (ex_if.imm_branch << BR_SHIFT);
  end

  // ALU; SUB shares the adder as A + ~B + 1
  always_comb begin
    b_eff_c = (ex_if.op == OP_SUB) ? ~b_c : b_c;
    sum_c   = {1'b0, a_c} + {1'b0, b_eff_c} + SUM_W'(ex_if.op == OP_SUB);
    res_c   = b_c;
    cy_c    = 1'b0;
    ov_c    = 1'b0;
    case (ex_if.op)
      OP_ADD, OP_SUB: begin
        res_c = sum_c[WIDTH-1:0];
        cy_c  = sum_c[WIDTH];
        ov_c  = (a_c[WIDTH-1] == b_eff_c[WIDTH-1]) && (sum_c[WIDTH-1] != a_c[WIDTH-1]);
      end
      OP_AND:  res_c = a_c & b_c;
      OP_OR:   res_c = a_c | b_c;
      OP_XOR:  res_c = a_c ^ b_c;
      OP_MUL:  res_c = '0;
      default: res_c = b_c;
    endcase
  end

  assign out_free_c = !valid_q || ex_if.out_ready;
  assign in_ready_c = !busy_q && out_free_c;
  assign accept_c   = ex_if.in_valid && in_ready_c;
  assign load_alu_c = accept_c && !mul_start_c;

`ifdef EX_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mdb_q;
  logic [WIDTH-1:0] mbpc_q;
  logic             mul_done_c;

  assign mul_start_c = accept_c && (ex_if.op == OP_MUL);
  assign mul_done_c  = (state_q == S_DONE) && out_free_c;

  // Shift-add multiplier sequencer; store data and branch target ride along for the result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mdb_q    <= '0;
      mbpc_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mul_start_c) begin
            mcand_q  <= a_c;
            mplier_q <= b_c;
            acc_q    <= '0;
            mdb_q    <= db_c;
            mbpc_q   <= bpc_c;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          if (out_free_c) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
`else
  assign mul_start_c = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy_q <= 1'b0;
    else        busy_q <= 1'b0;
  end
`endif

  // Result register: holds until consumed, reloads on the consuming edge when a new op is ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      alu_q   <= '0;
      db_q    <= '0;
      bpc_q   <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
    end else if (load_alu_c) begin
      valid_q <= 1'b1;
      alu_q   <= res_c;
      db_q    <= db_c;
      bpc_q   <= bpc_c;
      n_q     <= res_c[WIDTH-1];
      z_q     <= (db_c == '0);
      v_q     <= ov_c;
      c_q     <= cy_c;
`ifdef EX_MUL_EN
    end else if (mul_done_c) begin
      valid_q <= 1'b1;
      alu_q   <= acc_q;
      db_q    <= mdb_q;
      bpc_q   <= mbpc_q;
      n_q     <= acc_q[WIDTH-1];
      z_q     <= (mdb_q == '0);
      v_q     <= 1'b0;
      c_q     <= 1'b0;
`endif
    end else if (ex_if.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign ex_if.in_ready   = in_ready_c;
  assign ex_if.out_valid  = valid_q;
  assign ex_if.alu_out    = alu_q;
  assign ex_if.fwd_db_out = db_q;
  assign ex_if.branch_pc  = bpc_q;
  assign ex_if.negative   = n_q;
  assign ex_if.zero       = z_q;
  assign ex_if.overflow   = v_q;
  assign ex_if.carry      = c_q;
  assign ex_if.busy       = busy_q;

endmodule

// File: doc/ex_stage_mc.md
# ex_stage_mc

Parametrised, handshaked execute stage for the pipelined CPU. It replaces the fixed 64-bit single-cycle execute logic with a WIDTH-generic unit. The unit does operand forwarding, ALU-source selection, branch-target generation and the ALU ops, plus an optional iterative multiplier that takes several cycles. It sits between the ID/EX and EX/MEM pipeline registers. It exposes a valid/ready handshake on both sides so the hazard unit can stall ID while a multiply is running.

## Interface
Parameters:
- WIDTH, 64, datapath width in bits (≥8).
- BR_SHIFT, 2, left shift applied to the branch immediate.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  the ID/EX slot holds an instruction.
- in_ready  out  1  the stage accepts the instruction this cycle.
- op  in  3  000 pass-B, 001 MUL, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 pass-B.
- alu_src  in  2  B source: 00 forwarded Db, 01 imm12_ext, 10 imm9_ext, 11 zero.
- fwd_a, fwd_b  in  2 each  operand source: 00 register, 01 mem_fwd, 10 wb_fwd, 11 register.
- pc, da, db, imm12_ext, imm9_ext, imm_branch, mem_fwd, wb_fwd  in  WIDTH each  operands.
- out_valid  out  1  the result register holds a result.
- out_ready  in  1  EX/MEM consumes the result.
- alu_out, fwd_db_out, branch_pc  out  WIDTH each  registered results.
- negative, zero, overflow, carry  out  1 each  registered flags.
- busy  out  1  a multiply is in progress.

## Operation
- Accept happens when in_valid && in_ready, where in_ready = !busy && (!out_valid || out_ready).
- At accept, the unit resolves the forwarding muxes, the alu_src mux and branch_pc = pc + (imm_branch << BR_SHIFT), and latches them. Operand values after the accept edge have no effect.
- Non-MUL ops are computed combinationally from the latched operands and loaded into the output register on the accept edge.
- ADD/SUB use WIDTH-bit two's complement arithmetic. SUB is A + ~B + 1.
  - carry is the carry-out of bit WIDTH-1.
  - overflow is set when the operand signs match (the B sign is inverted for SUB) and the result sign differs.
- AND/OR/XOR/pass-B: carry = overflow = 0.
- negative = alu_out[WIDTH-1].
- zero = (fwd_db_out == 0), used for CBZ. It is not derived from the ALU result.
- fwd_db_out is the forwarded Db, registered for the store path.
- MUL FSM, IDLE → MUL → DONE → IDLE:
  - IDLE: accepting a MUL loads A into the multiplicand, B into the multiplier and clears the accumulator. busy goes to 1.
  - MUL: each cycle, if the multiplier LSB = 1 the multiplicand is added to the accumulator. Then the multiplicand shifts left by 1 and the multiplier shifts right by 1. A counter runs WIDTH cycles, then the FSM goes to DONE.
  - DONE: waits until the output register is free (!out_valid || out_ready). It then loads alu_out = low WIDTH bits of the product, overflow = carry = 0, and negative/zero per the rules above. It sets out_valid, clears busy and returns to IDLE.
- Output register: out_valid stays high and all outputs hold until out_ready. A new result may load in the same cycle the old one is consumed.

## Timing
- Reset values: out_valid 0, busy 0, in_ready 1, alu_out/fwd_db_out/branch_pc 0, all flags 0, FSM IDLE, counter 0.
- Reset asserted mid-multiply abandons the operation. No result is produced.
- Non-MUL latency is 1: result is visible the cycle after accept. Back-to-back throughput is 1 per cycle when out_ready = 1.
- MUL latency is WIDTH+2 cycles from accept to out_valid: 1 load cycle, WIDTH iterations, then DONE. Add any cycles DONE waits on a stalled output.
- in_ready is 0 throughout MUL and DONE.
- If in_valid and out_ready fall at the same time, out_valid clears after the handshake and no new result loads.

## Configuration
- EX_MUL_EN:
  - Defined: the multiplier and FSM are compiled in, as described above.
  - Undefined: op 001 completes as a single-cycle op with alu_out = 0 and all flags 0 except zero. busy is tied to 0.

## Test plan
- ADD forwarding, WIDTH=64: da=5, mem_fwd=7, db=3, fwd_a=01, alu_src=00, op=010 → next cycle alu_out=10, out_valid=1, carry=0, zero=0.
- SUB overflow: A=0x8000…0, B=1, op=011 → alu_out=0x7FFF…F, overflow=1, carry=1, negative=0.
- Branch and CBZ: pc=0x100, imm_branch=−4, db=0, op=000 → branch_pc=0xF0, zero=1.
- MUL with EX_MUL_EN, WIDTH=16: 300×7, out_ready=1 → busy for 17 cycles, in_ready=0, alu_out=2100 at cycle 18. A second instruction presented meanwhile is accepted only after out_valid.
- Backpressure: out_ready=0 with two ADDs queued → first result held stable, in_ready=0. Raise out_ready → second result loads on the same edge.
- Reset mid-MUL at cycle 5 → busy=0, out_valid=0, in_ready=1. The next ADD completes normally.
